// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//
// Request/response front-end for the single-port `memory` block. It accepts
// one read or write request at a time, drives the memory strobe for exactly
// one cycle, and captures read data one cycle after the read strobe. It then
// returns a response under valid/ready backpressure. Saturating completion
// counters track how many read and write responses were handed off.
//
// Ports
//   clk, reset     : clock; synchronous active-high reset
//   req_valid      : request present
//   req_ready      : controller can accept a request (IDLE only)
//   req_write      : 1 = write, 0 = read
//   req_addr       : request address
//   req_wdata      : write data (ignored for reads)
//   rsp_valid      : response present (RESP only)
//   rsp_ready      : consumer accepts the response
//   rsp_write      : echoes the accepted request's direction
//   rsp_rdata      : read data, 0 for write responses
//   mem_write_en   : memory write strobe
//   mem_read_en    : memory read strobe
//   mem_address    : memory address, holds last latched value
//   mem_w_data     : memory write data, holds last latched value
//   mem_r_data     : memory read data (registered inside the memory)
//   wr_count       : completed write responses, saturating
//   rd_count       : completed read responses, saturating
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int ADDR_WIDTH  = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_write,
  output logic [DATA_WIDTH-1:0]  rsp_rdata,
  output logic                   mem_write_en,
  output logic                   mem_read_en,
  output logic [ADDR_WIDTH-1:0]  mem_address,
  output logic [DATA_WIDTH-1:0]  mem_w_data,
  input  logic [DATA_WIDTH-1:0]  mem_r_data,
  output logic [COUNT_WIDTH-1:0] wr_count,
  output logic [COUNT_WIDTH-1:0] rd_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                 state, state_n;
  logic                   write_flag, write_flag_n;
  logic                   mem_write_en_n, mem_read_en_n;
  logic [ADDR_WIDTH-1:0]  mem_address_n;
  logic [DATA_WIDTH-1:0]  mem_w_data_n;
  logic                   rsp_write_n;
  logic [DATA_WIDTH-1:0]  rsp_rdata_n;
  logic [COUNT_WIDTH-1:0] wr_count_n, rd_count_n;

  // Handshake flags are pure state decodes so a response handshake can only
  // re-open the request side on the following cycle (no bypass path).
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // Every other output is a register; the whole datapath and the state are
  // loaded together from the next-value logic below.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      write_flag   <= 1'b0;
      mem_write_en <= 1'b0;
      mem_read_en  <= 1'b0;
      mem_address  <= '0;
      mem_w_data   <= '0;
      rsp_write    <= 1'b0;
      rsp_rdata    <= '0;
      wr_count     <= '0;
      rd_count     <= '0;
    end else begin
      state        <= state_n;
      write_flag   <= write_flag_n;
      mem_write_en <= mem_write_en_n;
      mem_read_en  <= mem_read_en_n;
      mem_address  <= mem_address_n;
      mem_w_data   <= mem_w_data_n;
      rsp_write    <= rsp_write_n;
      rsp_rdata    <= rsp_rdata_n;
      wr_count     <= wr_count_n;
      rd_count     <= rd_count_n;
    end
  end

  // Next-state and next-register logic. Everything holds by default; the
  // strobes default to 0 so they can only be high in the single ISSUE cycle
  // that follows an accepted request.
  always_comb begin
    state_n        = state;
    write_flag_n   = write_flag;
    mem_write_en_n = 1'b0;
    mem_read_en_n  = 1'b0;
    mem_address_n  = mem_address;
    mem_w_data_n   = mem_w_data;
    rsp_write_n    = rsp_write;
    rsp_rdata_n    = rsp_rdata;
    wr_count_n     = wr_count;
    rd_count_n     = rd_count;

    unique case (state)
      IDLE: begin
        if (req_valid) begin
          write_flag_n   = req_write;
          mem_address_n  = req_addr;
          mem_w_data_n   = req_wdata;
          // Strobes are registered, so raising them here puts exactly one
          // of them high during ISSUE.
          mem_write_en_n = req_write;
          mem_read_en_n  = !req_write;
          state_n        = ISSUE;
        end
      end

      ISSUE: begin
        if (write_flag) begin
          rsp_write_n = 1'b1;
          rsp_rdata_n = '0;
          state_n     = RESP;
        end else begin
          state_n     = CAPT;
        end
      end

      CAPT: begin
        // The memory registered r_data on the edge that closed ISSUE.
        rsp_write_n = 1'b0;
        rsp_rdata_n = mem_r_data;
        state_n     = RESP;
      end

      RESP: begin
        if (rsp_ready) begin
          if (rsp_write) begin
            if (wr_count != {COUNT_WIDTH{1'b1}}) begin
              wr_count_n = wr_count + COUNT_WIDTH'(1);
            end
          end else begin
            if (rd_count != {COUNT_WIDTH{1'b1}}) begin
              rd_count_n = rd_count + COUNT_WIDTH'(1);
            end
          end
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
